zone_flap_detector: RTL and testbench

Parametrised successor to the two-half dark-pixel comparator in the camera-to-game path. Splits each video frame into NUM_ZONES vertical strips and counts dark pixels per strip inside a margin window. At frame end it runs a sequential max/min scan over the strips. It then drives `birdfly_enable` and a one-cycle `flap_pulse` to the game logic, with hysteresis and multi-frame qualification.

---
 rtl/zone_flap_detector.sv | 184 ++++++++++++++++++
 tb/tb_zone_flap_detector.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zone_flap_detector.sv
// Per-strip dark-pixel counter with a frame-end max/min scan that drives a qualified flap output.
// Optional feature macro FLAP_HYST_EN: enable clears below DIFF_OFF instead of below DIFF_ON.
module zone_flap_detector #(
    parameter int unsigned H_ACTIVE    = 200,
    parameter int unsigned V_ACTIVE    = 164,
    parameter int unsigned NUM_ZONES   = 2,
    parameter int unsigned MARGIN      = 5,
    parameter int unsigned LUMA_THRESH = 128,
    parameter int unsigned CNT_W       = 15,
    parameter int unsigned DIFF_ON     = 2000,
    parameter int unsigned DIFF_OFF    = 1000,
    parameter int unsigned HOLD_FRAMES = 2,
    parameter int unsigned TRIG_ZONE   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pix_valid,
    input  logic [10:0]                  x_pos,
    input  logic [10:0]                  y_pos,
    input  logic [7:0]                   data_in,
    output logic                         birdfly_enable,
    output logic                         flap_pulse,
    output logic [$clog2(NUM_ZONES)-1:0] active_zone,
    output logic [CNT_W-1:0]             max_count,
    output logic [CNT_W-1:0]             diff_value,
    output logic                         frame_done,
    output logic                         overrun
);
    localparam int unsigned ZW = H_ACTIVE / NUM_ZONES;
    localparam int unsigned ZB = $clog2(NUM_ZONES);
    localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);

    localparam logic [10:0]       X_LO     = 11'(MARGIN);
    localparam logic [10:0]       X_HI     = 11'(H_ACTIVE - MARGIN);
    localparam logic [10:0]       Y_LO     = 11'(MARGIN);
    localparam logic [10:0]       Y_HI     = 11'(V_ACTIVE - MARGIN);
    localparam logic [10:0]       X_END    = 11'(H_ACTIVE - 1);
    localparam logic [10:0]       Y_END    = 11'(V_ACTIVE - 1);
    localparam logic [7:0]        LUMA_T   = 8'(LUMA_THRESH);
    localparam logic [ZB-1:0]     LAST_IDX = ZB'(NUM_ZONES - 1);
    localparam logic [ZB-1:0]     TRIG_IDX = ZB'(TRIG_ZONE);
    localparam logic [CNT_W-1:0]  ON_T     = CNT_W'(DIFF_ON);
`ifdef FLAP_HYST_EN
    localparam logic [CNT_W-1:0]  CLR_T    = CNT_W'(DIFF_OFF);
`else
    localparam logic [CNT_W-1:0]  CLR_T    = CNT_W'(DIFF_ON);
`endif
    localparam logic [HW:0]       HOLD_T   = (HW + 1)'(HOLD_FRAMES);

    typedef enum logic [1:0] {IDLE, EVAL, DECIDE} state_t;

    state_t                state, state_n;
    logic                  frame_end, frame_end_q, dark_in, decide;
    logic [NUM_ZONES-1:0]  hit;
    logic [CNT_W-1:0]      cnt  [NUM_ZONES];
    logic [CNT_W-1:0]      snap [NUM_ZONES];
    logic [ZB-1:0]         idx, scan_arg;
    logic [CNT_W-1:0]      scan_max, scan_min, diff;
    logic [HW-1:0]         hold_cnt, hold_n;
    logic [HW:0]           hold_inc;
    logic                  trig_hit, qual, en_n;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic h);
        return (h && (c != '1)) ? c + 1'b1 : c;
    endfunction

    assign frame_end = pix_valid && (x_pos == X_END) && (y_pos == Y_END);
    assign dark_in   = pix_valid && (data_in < LUMA_T) &&
                       (x_pos >= X_LO) && (x_pos < X_HI) &&
                       (y_pos >= Y_LO) && (y_pos < Y_HI);

    always_comb begin
        hit = '0;
        for (int unsigned z = 0; z < NUM_ZONES; z++) begin
            hit[z] = dark_in && (x_pos >= 11'(z * ZW)) && (x_pos < 11'((z + 1) * ZW));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned z = 0; z < NUM_ZONES; z++) begin
                cnt[z]  <= '0;
                snap[z] <= '0;
            end
        end else begin
            for (int unsigned z = 0; z < NUM_ZONES; z++) begin
                if (frame_end) begin
                    snap[z] <= sat_inc(cnt[z], hit[z]);
                    cnt[z]  <= '0;
                end else begin
                    cnt[z]  <= sat_inc(cnt[z], hit[z]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // frame_end_q is a one-cycle capture stage; any frame end seen while it is set or
    // while scanning/deciding aborts the frame in flight and restarts the scan.
    always_comb begin
        state_n = state;
        decide  = 1'b0;
        case (state)
            IDLE:   state_n = IDLE;
            EVAL:   if (idx == LAST_IDX) state_n = DECIDE;
            DECIDE: begin
                state_n = IDLE;
                decide  = !frame_end && !frame_end_q;
            end
            default: state_n = IDLE;
        endcase
        if (frame_end_q) state_n = EVAL;
    end

    always_comb begin
        diff     = scan_max - scan_min;
        trig_hit = (scan_arg == TRIG_IDX);
        qual     = trig_hit && (diff >= ON_T);
        hold_inc = {1'b0, hold_cnt} + 1'b1;
        hold_n   = '0;
        en_n     = birdfly_enable;
        if (qual) begin
            hold_n = (hold_inc >= HOLD_T) ? HOLD_T[HW-1:0] : hold_inc[HW-1:0];
            if (hold_inc >= HOLD_T) en_n = 1'b1;
        end else if (!trig_hit || (diff < CLR_T)) begin
            en_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_end_q    <= 1'b0;
            idx            <= '0;
            scan_max       <= '0;
            scan_min       <= '0;
            scan_arg       <= '0;
            hold_cnt       <= '0;
            birdfly_enable <= 1'b0;
            flap_pulse     <= 1'b0;
            active_zone    <= '0;
            max_count      <= '0;
            diff_value     <= '0;
            frame_done     <= 1'b0;
            overrun        <= 1'b0;
        end else begin
            frame_end_q <= frame_end;
            frame_done  <= 1'b0;
            flap_pulse  <= 1'b0;
            if (frame_end && ((state != IDLE) || frame_end_q)) overrun <= 1'b1;

            if (frame_end_q) begin
                idx <= '0;
            end else if (state == EVAL) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                if (idx == '0) begin
                    scan_max <= snap[idx];
                    scan_min <= snap[idx];
                    scan_arg <= '0;
                end else begin
                    // strict compare keeps the lowest index on ties
                    if (snap[idx] > scan_max) begin
                        scan_max <= snap[idx];
                        scan_arg <= idx;
                    end
                    if (snap[idx] < scan_min) scan_min <= snap[idx];
                end
            end

            if (decide) begin
                hold_cnt       <= hold_n;
                birdfly_enable <= en_n;
                flap_pulse     <= en_n & ~birdfly_enable;
                active_zone    <= scan_arg;
                max_count      <= scan_max;
                diff_value     <= diff;
                frame_done     <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_zone_flap_detector.sv
// Self-checking bench for zone_flap_detector: table-driven frames, corner sequences and
// randomized frames against a behavioural model of the dark-pixel/qualification rules.
module tb_zone_flap_detector;
    localparam int H = 200, V = 164, NZ = 2, MARGIN = 5, ZW = H / NZ;
    localparam int DIFF_ON = 2000, DIFF_OFF = 1000, HOLD = 2, TRIG = 1, CMAX = 32767;
`ifdef FLAP_HYST_EN
    localparam int HYST = 1;
`else
    localparam int HYST = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, pix_valid;
    logic [10:0] x_pos, y_pos;
    logic [7:0]  data_in;
    logic        birdfly_enable, flap_pulse, frame_done, overrun;
    logic [0:0]  active_zone;
    logic [14:0] max_count, diff_value;

    always #5 clk = ~clk;

    zone_flap_detector #(
        .H_ACTIVE(H), .V_ACTIVE(V), .NUM_ZONES(NZ), .MARGIN(MARGIN), .LUMA_THRESH(128),
        .CNT_W(15), .DIFF_ON(DIFF_ON), .DIFF_OFF(DIFF_OFF), .HOLD_FRAMES(HOLD), .TRIG_ZONE(TRIG)
    ) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .x_pos(x_pos), .y_pos(y_pos),
        .data_in(data_in), .birdfly_enable(birdfly_enable), .flap_pulse(flap_pulse),
        .active_zone(active_zone), .max_count(max_count), .diff_value(diff_value),
        .frame_done(frame_done), .overrun(overrun)
    );

    typedef struct {
        int n0; int n1; int zone; int mx; int df; int en; int pulse;
    } vec_t;
    vec_t tbl[10];

    int checks = 0, errors = 0, stray = 0;
    int mcnt[NZ];
    int snap[NZ];
    int mstreak, men, movr;
    int e_zone, e_max, e_diff, e_en, e_pulse;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int z = 0; z < NZ; z++) begin mcnt[z] = 0; snap[z] = 0; end
        mstreak = 0; men = 0; movr = 0;
    endtask

    // Drive one pixel for one clock and account for it in the model.
    task automatic px(input int x, input int y, input int d, input bit v);
        pix_valid = v; x_pos = 11'(x); y_pos = 11'(y); data_in = 8'(d);
        if (v && x >= MARGIN && x < H - MARGIN && y >= MARGIN && y < V - MARGIN && d < 128)
            if (mcnt[x / ZW] < CMAX) mcnt[x / ZW]++;
        @(posedge clk); #1;
    endtask

    task automatic take_snapshot();
        for (int z = 0; z < NZ; z++) begin snap[z] = mcnt[z]; mcnt[z] = 0; end
    endtask

    // Evaluate the frame-end rules on the snapshot and update the qualification state.
    task automatic model_frame();
        int q[$]; int t[$]; int ix[$]; int prev;
        q = {};
        for (int z = 0; z < NZ; z++) q.push_back(snap[z]);
        t = q.max(); e_max = t[0];
        t = q.min(); e_diff = e_max - t[0];
        ix = q.find_first_index(item) with (item == e_max);
        e_zone = ix[0];
        prev = men;
        if (e_zone == TRIG && e_diff >= DIFF_ON) mstreak++;
        else mstreak = 0;
        if (mstreak >= HOLD) men = 1;
        else if (e_zone != TRIG || e_diff < (HYST ? DIFF_OFF : DIFF_ON)) men = 0;
        e_en = men;
        e_pulse = (men == 1 && prev == 0) ? 1 : 0;
    endtask

    task automatic distract();
        int kind;
        kind = $urandom_range(2, 0);
        if (kind == 0)
            px($urandom_range(H - MARGIN - 1, MARGIN), $urandom_range(V - MARGIN - 1, MARGIN),
               $urandom_range(127, 0), 0);
        else if (kind == 1)
            px($urandom_range(H - MARGIN - 1, MARGIN), $urandom_range(V - MARGIN - 1, MARGIN),
               $urandom_range(255, 128), 1);
        else if ($urandom_range(1, 0) == 1)
            px($urandom_range(MARGIN - 1, 0), $urandom_range(V - 1, 0), $urandom_range(127, 0), 1);
        else
            px($urandom_range(H - 2, 0), $urandom_range(V - 1, V - MARGIN), $urandom_range(127, 0), 1);
    endtask

    task automatic fill(input int n0, input int n1, input bit rnd);
        int n[NZ];
        int xlo, xhi, w, x, y;
        n[0] = n0; n[1] = n1;
        for (int z = 0; z < NZ; z++) begin
            xlo = (z * ZW > MARGIN) ? z * ZW : MARGIN;
            xhi = ((z + 1) * ZW < H - MARGIN) ? (z + 1) * ZW : H - MARGIN;
            w = xhi - xlo;
            for (int k = 0; k < n[z]; k++) begin
                if (rnd) begin
                    x = $urandom_range(xhi - 1, xlo);
                    y = $urandom_range(V - MARGIN - 1, MARGIN);
                end else begin
                    x = xlo + k % w;
                    y = MARGIN + k / w;
                end
                px(x, y, $urandom_range(127, 0), 1);
                if ($urandom_range(15, 0) == 0) distract();
            end
        end
        for (int k = 0; k < 64; k++)
            px($urandom_range(H - MARGIN - 1, MARGIN), $urandom_range(V - MARGIN - 1, MARGIN),
               $urandom_range(255, 128), 1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            @(posedge clk); #1;
            if (frame_done) lat = k;
            else if (flap_pulse) stray++;
        end
    endtask

    task automatic end_frame(output int lat);
        px(H - 1, V - 1, $urandom_range(255, 0), 1);
        pix_valid = 1'b0;
        take_snapshot();
        model_frame();
        wait_done(lat);
    endtask

    task automatic check_outputs(input string tag, input int zone, input int mx, input int df,
                                 input int en, input int pulse, input int ovr);
        chk({tag, ".zone"},    32'(active_zone),    32'(zone));
        chk({tag, ".max"},     32'(max_count),      32'(mx));
        chk({tag, ".diff"},    32'(diff_value),     32'(df));
        chk({tag, ".enable"},  32'(birdfly_enable), 32'(en));
        chk({tag, ".pulse"},   32'(flap_pulse),     32'(pulse));
        chk({tag, ".overrun"}, 32'(overrun),        32'(ovr));
        @(posedge clk); #1;
        chk({tag, ".done_width"},  32'(frame_done), 32'd0);
        chk({tag, ".pulse_width"}, 32'(flap_pulse), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".enable"},  32'(birdfly_enable), 32'd0);
        chk({tag, ".pulse"},   32'(flap_pulse),     32'd0);
        chk({tag, ".zone"},    32'(active_zone),    32'd0);
        chk({tag, ".max"},     32'(max_count),      32'd0);
        chk({tag, ".diff"},    32'(diff_value),     32'd0);
        chk({tag, ".done"},    32'(frame_done),     32'd0);
        chk({tag, ".overrun"}, 32'(overrun),        32'd0);
    endtask

    initial begin
        int lat, dones, mode, n0, n1;
        tbl[0] = '{0,     0,     0, 0,     0,     0,    0};
        tbl[1] = '{0,     14630, 1, 14630, 14630, 0,    0};
        tbl[2] = '{0,     14630, 1, 14630, 14630, 1,    1};
        tbl[3] = '{0,     1500,  1, 1500,  1500,  HYST, 0};
        tbl[4] = '{0,     900,   1, 900,   900,   0,    0};
        tbl[5] = '{2500,  0,     0, 2500,  2500,  0,    0};
        tbl[6] = '{0,     2500,  1, 2500,  2500,  0,    0};
        tbl[7] = '{0,     2500,  1, 2500,  2500,  1,    1};
        tbl[8] = '{0,     2100,  1, 2100,  2100,  1,    0};
        tbl[9] = '{300,   300,   0, 300,   0,     0,    0};

        rst = 1'b1; pix_valid = 1'b0; x_pos = '0; y_pos = '0; data_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            fill(tbl[i].n0, tbl[i].n1, 1'b0);
            end_frame(lat);
            chk($sformatf("tbl%0d.latency", i), 32'(lat), 32'd4);
            check_outputs($sformatf("tbl%0d", i), tbl[i].zone, tbl[i].mx, tbl[i].df,
                          tbl[i].en, tbl[i].pulse, 0);
        end

        // Dark pixels only in the margin band or at out-of-range coordinates.
        for (int k = 0; k < 200; k++) begin
            case ($urandom_range(3, 0))
                0: px($urandom_range(MARGIN - 1, 0), $urandom_range(V - 1, 0), 0, 1);
                1: px($urandom_range(H - 2, 0), $urandom_range(V - 1, V - MARGIN), 0, 1);
                2: px($urandom_range(2047, H), $urandom_range(V - 2, 0), 0, 1);
                default: px($urandom_range(H - 2, 0), $urandom_range(2047, V), 0, 1);
            endcase
        end
        end_frame(lat);
        chk("margin.latency", 32'(lat), 32'd4);
        check_outputs("margin", 0, 0, 0, 0, 0, 0);

        // Second frame end two cycles after the first aborts the first evaluation.
        px(H - 1, V - 1, 0, 1);
        take_snapshot();
        px(0, 0, 0, 0);
        px(H - 1, V - 1, 0, 1);
        pix_valid = 1'b0;
        take_snapshot();
        model_frame();
        movr = 1;
        wait_done(lat);
        chk("overrun.latency", 32'(lat), 32'd4);
        check_outputs("overrun", 0, 0, 0, 0, 0, 1);
        dones = 0;
        repeat (8) begin @(posedge clk); #1; dones += int'(frame_done); end
        chk("overrun.extra_done", 32'(dones), 32'd0);

        // Reset asserted while the scan is running.
        for (int f = 0; f < 2; f++) begin
            fill(0, 2500, 1'b1);
            end_frame(lat);
            chk($sformatf("prerst%0d.latency", f), 32'(lat), 32'd4);
            check_outputs($sformatf("prerst%0d", f), e_zone, e_max, e_diff, e_en, e_pulse, movr);
        end
        fill(0, 2500, 1'b1);
        px(H - 1, V - 1, 0, 1);
        take_snapshot();
        px(0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_all_zero("rst_eval");
        dones = 0;
        repeat (10) begin @(posedge clk); #1; dones += int'(frame_done); end
        chk("rst_eval.no_done", 32'(dones), 32'd0);
        fill(0, 2500, 1'b1);
        end_frame(lat);
        chk("postrst.latency", 32'(lat), 32'd4);
        check_outputs("postrst", 1, 2500, 2500, 0, 0, 0);

        for (int f = 0; f < 6; f++) begin
            mode = $urandom_range(3, 0);
            case (mode)
                0: begin n0 = $urandom_range(400, 0); n1 = n0 + $urandom_range(2400, 1800); end
                1: begin n0 = $urandom_range(400, 0); n1 = n0 + $urandom_range(1600, 900); end
                2: begin n0 = $urandom_range(2500, 500); n1 = $urandom_range(500, 0); end
                default: begin n0 = $urandom_range(2000, 0); n1 = $urandom_range(2000, 0); end
            endcase
            fill(n0, n1, 1'b1);
            end_frame(lat);
            chk($sformatf("rnd%0d.latency", f), 32'(lat), 32'd4);
            check_outputs($sformatf("rnd%0d", f), e_zone, e_max, e_diff, e_en, e_pulse, movr);
        end

        chk("stray_pulse", 32'(stray), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
